// File: rtl/mainfsm_if.sv
// ---------------------------------------------------------------------------
// mainfsm_if -- shared instruction/data memory port of the multicycle core.
//
// Signals:
//   mem_req    request from the controller, held until mem_ready
//   mem_ready  memory completed the current request this cycle
//   iord       address select: 0 = PC (fetch), 1 = ALU result register
//   memwrite   store size: 00 none, 01 word, 10 byte, 11 doubleword
//   readtype   load type: 000 LW, 001 LWU, 010 LB, 011 LBU, 100 LD
//
// Modports:
//   master  controller side (drives the request, sees mem_ready)
//   slave   memory side
// ---------------------------------------------------------------------------
interface mainfsm_if;
    logic       mem_req;
    logic       mem_ready;
    logic       iord;
    logic [1:0] memwrite;
    logic [2:0] readtype;

    modport master (
        output mem_req,
        output iord,
        output memwrite,
        output readtype,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  iord,
        input  memwrite,
        input  readtype,
        output mem_ready
    );
endinterface

// File: rtl/mainfsm.sv
// ---------------------------------------------------------------------------
// mainfsm -- multicycle main control FSM of the MIPS core.
//
// Sequences each instruction through FETCH, DECODE, execute, memory and
// writeback states over a single shared instruction/data memory port with a
// request/ready handshake (unbounded wait states).
//
// Parameters:
//   XLEN  datapath width, 32 or 64. At 32 the opcodes LD, SD, LWU and DADDI
//         are treated as illegal.
//
// Configuration macro:
//   MAINFSM_ILLEGAL_TRAP_EN  defined:   an illegal opcode enters TRAP and sets
//                                       the sticky illegal_op flag; TRAP holds
//                                       every output at 0 until reset.
//                            undefined: an illegal opcode executes as a NOP
//                                       and illegal_op is tied to 0.
//
// Ports:
//   clk        core clock, rising edge
//   reset      asynchronous, active-low reset
//   op         opcode field of the instruction register, sampled in DECODE
//   mem        memory handshake (mainfsm_if.master)
//   irwrite    load instruction register (FETCH with mem_ready only)
//   pcwrite    load PC (FETCH with mem_ready, or JUMP)
//   regwrite   register file write enable
//   memtoreg   write-data select, 1 = memory
//   regdst     destination select, 1 = rd
//   alusrca    0 = PC, 1 = register A
//   alusrcb    000 B, 001 sext imm, 010 zext imm, 011 const 4, 100 sext imm<<2
//   aluop      000 add, 001 and, 010 or, 011 slt, 100 dadd, 101 sub, 111 funct
//   pcsrc      00 ALU result, 01 ALU output register, 10 jump target
//   branch     conditional PC write on zero
//   bne        conditional PC write on not-zero
//   state      current state, for debug
//   illegal_op sticky illegal-opcode flag
// ---------------------------------------------------------------------------
module mainfsm #(
    parameter int XLEN = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    mainfsm_if.master  mem,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [2:0] alusrcb,
    output logic [2:0] aluop,
    output logic [1:0] pcsrc,
    output logic       branch,
    output logic       bne,
    output logic [3:0] state,
    output logic       illegal_op
);

    // -----------------------------------------------------------------------
    // Opcodes
    // -----------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_DADDI = 6'b011000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LD    = 6'b110111;
    localparam logic [5:0] OP_SD    = 6'b111111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_ALUWB  = 4'd7,
        S_IEXE   = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd15
    } state_e;

    typedef enum logic [2:0] {
        K_RTYPE,
        K_LOAD,
        K_STORE,
        K_IMM,
        K_BRANCH,
        K_JUMP,
        K_ILLEGAL
    } kind_e;

    // Registered Moore outputs (everything except the mem_ready-gated
    // irwrite and the fetch half of pcwrite).
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       pcwrite;
        logic [1:0] memwrite;
        logic [2:0] readtype;
        logic       regwrite;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [2:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       branch;
        logic       bne;
    } ctrl_t;

    // -----------------------------------------------------------------------
    // Opcode decode helpers
    // -----------------------------------------------------------------------
    function automatic kind_e classify(input logic [5:0] o);
        kind_e k;
        case (o)
            OP_RTYPE:                                     k = K_RTYPE;
            OP_LD, OP_LWU, OP_LW, OP_LBU, OP_LB:          k = K_LOAD;
            OP_SD, OP_SW, OP_SB:                          k = K_STORE;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_DADDI:  k = K_IMM;
            OP_BEQ, OP_BNE:                               k = K_BRANCH;
            OP_J:                                         k = K_JUMP;
            default:                                      k = K_ILLEGAL;
        endcase
        // Doubleword and unsigned-word opcodes only exist on a 64-bit datapath.
        if (XLEN == 32 && (o == OP_LD || o == OP_SD || o == OP_LWU || o == OP_DADDI))
            k = K_ILLEGAL;
        return k;
    endfunction

    function automatic logic [2:0] load_type(input logic [5:0] o);
        case (o)
            OP_LD:   return 3'b100;
            OP_LWU:  return 3'b001;
            OP_LBU:  return 3'b011;
            OP_LB:   return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] store_size(input logic [5:0] o);
        case (o)
            OP_SD:   return 2'b11;
            OP_SW:   return 2'b01;
            OP_SB:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Logical immediates are zero-extended, arithmetic ones sign-extended.
    function automatic logic [2:0] imm_srcb(input logic [5:0] o);
        case (o)
            OP_ANDI, OP_ORI: return 3'b010;
            default:         return 3'b001;
        endcase
    endfunction

    function automatic logic [2:0] imm_aluop(input logic [5:0] o);
        case (o)
            OP_ANDI:  return 3'b001;
            OP_ORI:   return 3'b010;
            OP_SLTI:  return 3'b011;
            OP_DADDI: return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

    // Output decode for a given state and latched opcode. Applied to the
    // next state so the result can be registered alongside it.
    function automatic ctrl_t ctrl_for(input state_e s, input logic [5:0] o);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.alusrcb = 3'b011;
            end
            S_DECODE: begin
                c.alusrcb = 3'b100;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 3'b001;
            end
            S_MEMRD: begin
                c.mem_req  = 1'b1;
                c.iord     = 1'b1;
                c.readtype = load_type(o);
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
                c.readtype = load_type(o);
            end
            S_MEMWR: begin
                c.mem_req  = 1'b1;
                c.iord     = 1'b1;
                c.memwrite = store_size(o);
            end
            S_RTEXE: begin
                c.alusrca = 1'b1;
                c.aluop   = 3'b111;
            end
            S_ALUWB: begin
                c.regwrite = 1'b1;
                c.regdst   = (o == OP_RTYPE);
            end
            S_IEXE: begin
                c.alusrca = 1'b1;
                c.alusrcb = imm_srcb(o);
                c.aluop   = imm_aluop(o);
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = 3'b101;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
                c.bne     = (o == OP_BNE);
            end
            S_JUMP: begin
                c.pcwrite = 1'b1;
                c.pcsrc   = 2'b10;
            end
            default: ;  // TRAP: everything held at 0
        endcase
        return c;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    ctrl_t      ctrl_q;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
    logic       illegal_q;
    logic       illegal_set;
`endif

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
        illegal_set = 1'b0;
`endif
        case (state_q)
            S_FETCH:  if (mem.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d = op;
                case (classify(op))
                    K_RTYPE:  state_d = S_RTEXE;
                    K_LOAD,
                    K_STORE:  state_d = S_MEMADR;
                    K_IMM:    state_d = S_IEXE;
                    K_BRANCH: state_d = S_BRANCH;
                    K_JUMP:   state_d = S_JUMP;
                    default: begin
`ifdef MAINFSM_ILLEGAL_TRAP_EN
                        state_d     = S_TRAP;
                        illegal_set = 1'b1;
`else
                        state_d     = S_FETCH;  // executes as a NOP
`endif
                    end
                endcase
            end
            S_MEMADR: state_d = (classify(op_q) == K_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem.mem_ready) state_d = S_FETCH;
            S_RTEXE,
            S_IEXE:   state_d = S_ALUWB;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;  // MEMWB, ALUWB, BRANCH, JUMP
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            ctrl_q  <= ctrl_for(S_FETCH, 6'd0);
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_for(state_d, op_d);
        end
    end

`ifdef MAINFSM_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          illegal_q <= 1'b0;
        else if (illegal_set) illegal_q <= 1'b1;
    end
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The fetch write strobes follow mem_ready combinationally; reset is
    // folded in so a ready memory cannot load IR/PC while held in reset.
    logic fetch_accept;
    assign fetch_accept = (state_q == S_FETCH) && mem.mem_ready && reset;

    assign irwrite      = fetch_accept;
    assign pcwrite      = ctrl_q.pcwrite | fetch_accept;

    assign mem.mem_req  = ctrl_q.mem_req;
    assign mem.iord     = ctrl_q.iord;
    assign mem.memwrite = ctrl_q.memwrite;
    assign mem.readtype = ctrl_q.readtype;

    assign regwrite     = ctrl_q.regwrite;
    assign memtoreg     = ctrl_q.memtoreg;
    assign regdst       = ctrl_q.regdst;
    assign alusrca      = ctrl_q.alusrca;
    assign alusrcb      = ctrl_q.alusrcb;
    assign aluop        = ctrl_q.aluop;
    assign pcsrc        = ctrl_q.pcsrc;
    assign branch       = ctrl_q.branch;
    assign bne          = ctrl_q.bne;
    assign state        = state_q;

endmodule

// File: tb/tb_mainfsm.sv
// ---------------------------------------------------------------------------
// tb_mainfsm -- scoreboard bench for mainfsm.
//
// Two instances run side by side: dut0 with XLEN=64 and dut1 with XLEN=32.
// For every instruction the reference model expands the opcode into its
// cycle-by-cycle schedule (inputs to drive plus the outputs expected in that
// cycle). A player drives each cycle just after the rising edge and pushes
// the expected outputs into a per-instance queue; a monitor pops and
// compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_mainfsm;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_DADDI = 6'b011000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LD    = 6'b110111;
    localparam logic [5:0] OP_SD    = 6'b111111;

`ifdef MAINFSM_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic [1:0] memwrite;
        logic [2:0] readtype;
        logic       regwrite;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [2:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       branch;
        logic       bne;
        logic       illegal_op;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       rdy;
        logic [5:0] op;
        obs_t       exp;
    } cyc_t;

    logic clk;
    logic rst0, rst1;
    logic [5:0] op0, op1;

    logic       irw0, pcw0, rw0, mtr0, rd0, asa0, br0, bne0, ill0;
    logic [2:0] asb0, aop0;
    logic [1:0] pcs0;
    logic [3:0] st0;
    logic       irw1, pcw1, rw1, mtr1, rd1, asa1, br1, bne1, ill1;
    logic [2:0] asb1, aop1;
    logic [1:0] pcs1;
    logic [3:0] st1;

    mainfsm_if if0 ();
    mainfsm_if if1 ();

    mainfsm #(.XLEN(64)) dut0 (
        .clk(clk), .reset(rst0), .op(op0), .mem(if0),
        .irwrite(irw0), .pcwrite(pcw0), .regwrite(rw0), .memtoreg(mtr0),
        .regdst(rd0), .alusrca(asa0), .alusrcb(asb0), .aluop(aop0),
        .pcsrc(pcs0), .branch(br0), .bne(bne0), .state(st0), .illegal_op(ill0)
    );

    mainfsm #(.XLEN(32)) dut1 (
        .clk(clk), .reset(rst1), .op(op1), .mem(if1),
        .irwrite(irw1), .pcwrite(pcw1), .regwrite(rw1), .memtoreg(mtr1),
        .regdst(rd1), .alusrca(asa1), .alusrcb(asb1), .aluop(aop1),
        .pcsrc(pcs1), .branch(br1), .bne(bne1), .state(st1), .illegal_op(ill1)
    );

    obs_t obs0, obs1;
    assign obs0 = {st0, if0.mem_req, if0.iord, irw0, pcw0, if0.memwrite, if0.readtype,
                   rw0, mtr0, rd0, asa0, asb0, aop0, pcs0, br0, bne0, ill0};
    assign obs1 = {st1, if1.mem_req, if1.iord, irw1, pcw1, if1.memwrite, if1.readtype,
                   rw1, mtr1, rd1, asa1, asb1, aop1, pcs1, br1, bne1, ill1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    cyc_t sched0[$], sched1[$];
    obs_t exp_q0[$], exp_q1[$];
    bit   model_ill[2];
    int   cyc_cnt[2];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   done0 = 1'b0, done1 = 1'b0;

    // -----------------------------------------------------------------------
    // Reference model: expands instructions into per-cycle expectations.
    // -----------------------------------------------------------------------
    function automatic logic [5:0] junk();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t blank(input int d, input logic [3:0] st);
        obs_t o;
        o = '0;
        o.state = st;
        o.illegal_op = model_ill[d];
        return o;
    endfunction

    task automatic push(input int d, input logic rst, input logic rdy,
                        input logic [5:0] opv, input obs_t e);
        cyc_t c;
        c.rst = rst;
        c.rdy = rdy;
        c.op  = opv;
        c.exp = e;
        if (d == 0) sched0.push_back(c);
        else        sched1.push_back(c);
    endtask

    // Reset held for n cycles: FETCH outputs, no IR/PC write, flag cleared.
    task automatic add_reset(input int d, input int n);
        obs_t e;
        model_ill[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            e = blank(d, 4'd0);
            e.mem_req = 1'b1;
            e.alusrcb = 3'b011;
            push(d, 1'b0, rbit(), junk(), e);
        end
    endtask

    // wf / wm: wait cycles before mem_ready in FETCH / in the data access.
    // abort: reset arrives while a load is stalled in its data access.
    task automatic add_instr(input int d, input logic [5:0] opc,
                             input int wf, input int wm, input bit abort);
        obs_t e;
        logic rdy;
        bit   only64;
        only64 = (d == 1) && (opc inside {OP_LD, OP_SD, OP_LWU, OP_DADDI});

        for (int i = 0; i <= wf; i++) begin
            rdy = (i == wf);
            e = blank(d, 4'd0);
            e.mem_req = 1'b1;
            e.alusrcb = 3'b011;
            e.irwrite = rdy;
            e.pcwrite = rdy;
            push(d, 1'b1, rdy, junk(), e);
        end

        e = blank(d, 4'd1);
        e.alusrcb = 3'b100;
        push(d, 1'b1, rbit(), opc, e);

        if (!only64 && opc inside {OP_LD, OP_LWU, OP_LW, OP_LBU, OP_LB}) begin
            logic [2:0] rt;
            case (opc)
                OP_LD:   rt = 3'b100;
                OP_LWU:  rt = 3'b001;
                OP_LBU:  rt = 3'b011;
                OP_LB:   rt = 3'b010;
                default: rt = 3'b000;
            endcase
            e = blank(d, 4'd2);
            e.alusrca = 1'b1;
            e.alusrcb = 3'b001;
            push(d, 1'b1, rbit(), junk(), e);
            for (int i = 0; i <= wm; i++) begin
                rdy = (i == wm);
                if (abort && rdy) begin
                    add_reset(d, 2);
                    return;
                end
                e = blank(d, 4'd3);
                e.mem_req  = 1'b1;
                e.iord     = 1'b1;
                e.readtype = rt;
                push(d, 1'b1, rdy, junk(), e);
            end
            e = blank(d, 4'd4);
            e.regwrite = 1'b1;
            e.memtoreg = 1'b1;
            e.readtype = rt;
            push(d, 1'b1, rbit(), junk(), e);
        end else if (!only64 && opc inside {OP_SD, OP_SW, OP_SB}) begin
            e = blank(d, 4'd2);
            e.alusrca = 1'b1;
            e.alusrcb = 3'b001;
            push(d, 1'b1, rbit(), junk(), e);
            for (int i = 0; i <= wm; i++) begin
                rdy = (i == wm);
                e = blank(d, 4'd5);
                e.mem_req  = 1'b1;
                e.iord     = 1'b1;
                e.memwrite = (opc == OP_SD) ? 2'b11 : (opc == OP_SW) ? 2'b01 : 2'b10;
                push(d, 1'b1, rdy, junk(), e);
            end
        end else if (opc == OP_RTYPE) begin
            e = blank(d, 4'd6);
            e.alusrca = 1'b1;
            e.aluop   = 3'b111;
            push(d, 1'b1, rbit(), junk(), e);
            e = blank(d, 4'd7);
            e.regwrite = 1'b1;
            e.regdst   = 1'b1;
            push(d, 1'b1, rbit(), junk(), e);
        end else if (!only64 && opc inside {OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_DADDI}) begin
            e = blank(d, 4'd8);
            e.alusrca = 1'b1;
            case (opc)
                OP_ANDI:  begin e.alusrcb = 3'b010; e.aluop = 3'b001; end
                OP_ORI:   begin e.alusrcb = 3'b010; e.aluop = 3'b010; end
                OP_SLTI:  begin e.alusrcb = 3'b001; e.aluop = 3'b011; end
                OP_DADDI: begin e.alusrcb = 3'b001; e.aluop = 3'b100; end
                default:  begin e.alusrcb = 3'b001; e.aluop = 3'b000; end
            endcase
            push(d, 1'b1, rbit(), junk(), e);
            e = blank(d, 4'd7);
            e.regwrite = 1'b1;
            push(d, 1'b1, rbit(), junk(), e);
        end else if (opc == OP_BEQ || opc == OP_BNE) begin
            e = blank(d, 4'd9);
            e.alusrca = 1'b1;
            e.aluop   = 3'b101;
            e.pcsrc   = 2'b01;
            e.branch  = 1'b1;
            e.bne     = (opc == OP_BNE);
            push(d, 1'b1, rbit(), junk(), e);
        end else if (opc == OP_J) begin
            e = blank(d, 4'd10);
            e.pcwrite = 1'b1;
            e.pcsrc   = 2'b10;
            push(d, 1'b1, rbit(), junk(), e);
        end else if (TRAP_EN) begin
            // Illegal with trapping: stuck in TRAP with the flag set until reset.
            model_ill[d] = 1'b1;
            for (int i = 0; i < 3; i++) push(d, 1'b1, rbit(), junk(), blank(d, 4'd15));
            add_reset(d, 2);
        end
        // Illegal without trapping: DECODE falls straight back to FETCH.
    endtask

    task automatic add_random(input int d, input int n);
        logic [5:0] ops[17] = '{OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
                                OP_ANDI, OP_ORI, OP_DADDI, OP_LB, OP_LW, OP_LBU,
                                OP_LWU, OP_SB, OP_SW, OP_LD, OP_SD};
        logic [5:0] opc;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) < 8) opc = ops[$urandom_range(0, 16)];
            else                          opc = junk();
            add_instr(d, opc, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        end
    endtask

    // -----------------------------------------------------------------------
    // Player: one scheduled cycle per clock, driven just after the edge.
    // -----------------------------------------------------------------------
    task automatic play(input int d);
        cyc_t c;
        while ((d == 0 ? sched0.size() : sched1.size()) > 0) begin
            if (d == 0) c = sched0.pop_front();
            else        c = sched1.pop_front();
            @(posedge clk);
            #1;
            if (d == 0) begin
                rst0 = c.rst; op0 = c.op; if0.mem_ready = c.rdy;
                exp_q0.push_back(c.exp);
            end else begin
                rst1 = c.rst; op1 = c.op; if1.mem_ready = c.rdy;
                exp_q1.push_back(c.exp);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    task automatic compare(input int d, input obs_t e, input obs_t g);
        n_checks++;
        if (g === e) n_pass++;
        else $display("FAIL dut%0d cycle %0d outputs: got %h (state %0d) expected %h (state %0d) diff %h",
                      d, cyc_cnt[d], g, g.state, e, e.state, g ^ e);
        cyc_cnt[d]++;
    endtask

    always @(negedge clk) begin
        if (exp_q0.size() > 0) compare(0, exp_q0.pop_front(), obs0);
        if (exp_q1.size() > 0) compare(1, exp_q1.pop_front(), obs1);
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        rst0 = 1'b0; op0 = '0; if0.mem_ready = 1'b0;
        add_reset(0, 2);
        add_instr(0, OP_LW, 0, 2, 1'b1);     // reset while stalled in MEMRD
        add_instr(0, OP_LW, 0, 0, 1'b0);     // zero-wait load, 5 cycles
        add_instr(0, OP_SB, 0, 3, 1'b0);     // 3 wait states in MEMWR, 7 cycles
        add_instr(0, OP_BNE, 0, 0, 1'b0);
        add_instr(0, OP_ANDI, 0, 0, 1'b0);
        add_instr(0, OP_ORI, 0, 0, 1'b0);
        add_instr(0, OP_BEQ, 1, 0, 1'b0);
        add_instr(0, OP_J, 2, 0, 1'b0);
        add_instr(0, OP_RTYPE, 0, 0, 1'b0);
        add_instr(0, OP_LD, 0, 1, 1'b0);
        add_instr(0, OP_SD, 1, 0, 1'b0);
        add_instr(0, OP_DADDI, 0, 0, 1'b0);
        add_instr(0, 6'b111010, 0, 0, 1'b0); // unassigned opcode
        add_instr(0, OP_LW, 0, 0, 1'b0);
        add_random(0, 60);
        play(0);
        done0 = 1'b1;
    end

    initial begin
        rst1 = 1'b0; op1 = '0; if1.mem_ready = 1'b0;
        add_reset(1, 2);
        add_instr(1, OP_LD, 0, 0, 1'b0);     // 64-bit-only opcode on XLEN=32
        add_instr(1, OP_LW, 1, 1, 1'b0);
        add_instr(1, OP_DADDI, 0, 0, 1'b0);
        add_instr(1, OP_SW, 0, 2, 1'b0);
        add_instr(1, OP_LWU, 0, 0, 1'b0);
        add_instr(1, OP_SD, 0, 0, 1'b0);
        add_instr(1, OP_SLTI, 0, 0, 1'b0);
        add_instr(1, OP_LBU, 0, 0, 1'b0);
        add_random(1, 60);
        play(1);
        done1 = 1'b1;
    end

    initial begin
        wait (done0 && done1);
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q0.size() == 0 && exp_q1.size() == 0) n_pass++;
        else $display("FAIL scoreboard drain: got %0d/%0d entries left, required 0/0",
                      exp_q0.size(), exp_q1.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of stimulus, required completion within time limit");
        $fatal(1);
    end

endmodule
